// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and small helpers for the VGA timing
// generator and for the pixel-generation logic that consumes its outputs.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // 100 MHz system clock divided down to the 25 MHz pixel rate
    localparam int DIV_RATIO = 4;
    localparam int DIV_W     = 2;
    localparam int CNT_W     = 10;

    function automatic logic in_window(input logic [CNT_W-1:0] v,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of the VGA timing outputs: the generator drives it (master), pixel
// logic and monitors observe it (slave).
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             p_tick;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             frame_tick;

    modport master (output hsync, vsync, video_on, p_tick, x, y, frame_tick);
    modport slave  (input  hsync, vsync, video_on, p_tick, x, y, frame_tick);

endinterface

// File: rtl/pixel_tick_div.sv
// Free-running divide-by-4 of the system clock; p_tick marks the last clk of
// each pixel, i.e. the edge on which the pixel counters advance.
module pixel_tick_div
    import vga_timing_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    logic [DIV_W-1:0] div;

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign p_tick = (div == DIV_W'(DIV_RATIO - 1));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters plus registered syncs,
// display-enable and frame pulse, all aligned to the same clk as x and y.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISP = vga_timing_pkg::H_DISPLAY,
    parameter int H_FP   = vga_timing_pkg::H_FRONT,
    parameter int H_SW   = vga_timing_pkg::H_SYNC,
    parameter int H_BP   = vga_timing_pkg::H_BACK,
    parameter int V_DISP = vga_timing_pkg::V_DISPLAY,
    parameter int V_FP   = vga_timing_pkg::V_FRONT,
    parameter int V_SW   = vga_timing_pkg::V_SYNC,
    parameter int V_BP   = vga_timing_pkg::V_BACK
)(
    input  logic             clk,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             p_tick,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_tick
);

    localparam logic [CNT_W-1:0] X_MAX = CNT_W'(H_DISP + H_FP + H_SW + H_BP - 1);
    localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(V_DISP + V_FP + V_SW + V_BP - 1);
    localparam logic [CNT_W-1:0] HS_LO = CNT_W'(H_DISP + H_FP);
    localparam logic [CNT_W-1:0] HS_HI = CNT_W'(H_DISP + H_FP + H_SW - 1);
    localparam logic [CNT_W-1:0] VS_LO = CNT_W'(V_DISP + V_FP);
    localparam logic [CNT_W-1:0] VS_HI = CNT_W'(V_DISP + V_FP + V_SW - 1);
    localparam logic [CNT_W-1:0] X_VIS = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] Y_VIS = CNT_W'(V_DISP);

    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_next;
    logic             frame_next;

    pixel_tick_div u_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    always_comb begin
        x_next     = x;
        y_next     = y;
        frame_next = 1'b0;
        if (p_tick) begin
            if (x == X_MAX) begin
                x_next = '0;
                if (y == Y_MAX) begin
                    y_next     = '0;
                    frame_next = 1'b1;
                end else begin
                    y_next = y + 1'b1;
                end
            end else begin
                x_next = x + 1'b1;
            end
        end
    end

    // Decoding next-state values keeps syncs and video_on in step with x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            video_on   <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            x          <= x_next;
            y          <= y_next;
            hsync      <= !in_window(x_next, HS_LO, HS_HI);
            vsync      <= !in_window(y_next, VS_LO, VS_HI);
            video_on   <= (x_next < X_VIS) && (y_next < Y_VIS);
            frame_tick <= frame_next;
        end
    end

endmodule
